sub4_serial: RTL and testbench

SUB4_SERIAL -- requirements
Module: sub4_serial

---
 rtl/sub4_serial.sv | 116 +++++++++++
 tb/tb_sub4_serial.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub4_serial.sv
// Bit-serial WIDTH-bit subtractor: one result bit per cycle, LSB first, IDLE/RUN/DONE handshake.
// Optional zero/overflow flags when SUB4_SERIAL_FLAGS_EN is defined.
module sub4_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB4_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             overflow
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             bor_q;
    logic [CW-1:0]    cnt_q;

    logic accept;
    logic last_bit;
    logic d_bit;
    logic bor_next;

    always_comb begin
        accept   = (state_q != StRun) && start;
        last_bit = (cnt_q == CW'(WIDTH - 1));
        d_bit    = a_q[0] ^ b_q[0] ^ bor_q;
        bor_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register is not cleared on accept; it is only meaningful from done onward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            bor_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            bor_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == StRun) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= {d_bit, res_q[WIDTH-1:1]};
            bor_q <= bor_next;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign diff       = res_q;
    assign borrow_out = bor_q;

`ifdef SUB4_SERIAL_FLAGS_EN
    logic a_msb_q, b_msb_q;
    logic zero_q, ovf_q;

    // Flags latch on the final RUN cycle, where d_bit is the result sign bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == StRun && last_bit) begin
            zero_q <= ({d_bit, res_q[WIDTH-1:1]} == '0);
            ovf_q  <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
        end
    end

    assign zero     = zero_q;
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_sub4_serial.sv
// Directed self-checking bench for sub4_serial at WIDTH=4; flag checks only when
// SUB4_SERIAL_FLAGS_EN is defined.
module tb_sub4_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SUB4_SERIAL_FLAGS_EN
    logic         zero;
    logic         overflow;
`endif

    int tests;
    int fails;

    sub4_serial #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out)
`ifdef SUB4_SERIAL_FLAGS_EN
        ,
        .zero      (zero),
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Checks W busy cycles following an accept edge, leaving time in the DONE cycle.
    task automatic check_run(input string name);
        for (int i = 0; i < W; i++) begin
            tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s run cycle %0d: busy=%b done=%b, want busy=1 done=0",
                         name, i, busy, done);
            end
            step();
        end
    endtask

    task automatic check_done(input string name, input logic [W-1:0] ed, input logic eb);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || diff !== ed || borrow_out !== eb) begin
            fails++;
            $display("FAIL %s done: done=%b busy=%b diff=%h bor=%b, want 1 0 %h %b",
                     name, done, busy, diff, borrow_out, ed, eb);
        end
    endtask

    task automatic check_flags(input string name, input logic ez, input logic eo);
`ifdef SUB4_SERIAL_FLAGS_EN
        tests++;
        if (zero !== ez || overflow !== eo) begin
            fails++;
            $display("FAIL %s flags: zero=%b ovf=%b, want %b %b", name, zero, overflow, ez, eo);
        end
`else
        if (ez === 1'bx || eo === 1'bx) $display("flags %s not compiled in", name);
`endif
    endtask

    // Leave DONE with start low; done must drop and the result must stay put.
    task automatic check_after(input string name, input logic [W-1:0] ed, input logic eb);
        step();
        a = 4'hA;
        b = 4'h6;
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== ed || borrow_out !== eb) begin
            fails++;
            $display("FAIL %s hold: done=%b busy=%b diff=%h bor=%b, want 0 0 %h %b",
                     name, done, busy, diff, borrow_out, ed, eb);
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W-1:0] ed, input logic eb, input logic ez, input logic eo);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        step();
        start = 1'b0;
        check_run(name);
        check_done(name, ed, eb);
        check_flags(name, ez, eo);
        check_after(name, ed, eb);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1;
        a     = 4'hF;
        b     = 4'h1;
        step();
        step();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'h0 || borrow_out !== 1'b0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b diff=%h bor=%b, want 0 0 0 0",
                     busy, done, diff, borrow_out);
        end
        check_flags("reset", 1'b0, 1'b0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_basic;
        do_op("7-3", 4'h7, 4'h3, 4'h4, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_borrow;
        do_op("3-7", 4'h3, 4'h7, 4'hC, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow;
        do_op("8-1", 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_zero;
        do_op("5-5", 4'h5, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        a     = 4'h9;
        b     = 4'h2;
        start = 1'b1;
        step();
        // New operands and start held during RUN must not disturb the first op.
        a = 4'h1;
        b = 4'h2;
        check_run("b2b first");
        check_done("b2b first", 4'h7, 1'b0);
        check_flags("b2b first", 1'b0, 1'b1);
        step();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b relaunch: busy=%b done=%b, want 1 0", busy, done);
        end
        step();
        for (int i = 1; i < W; i++) step();
        check_done("b2b second", 4'hF, 1'b1);
        check_flags("b2b second", 1'b0, 1'b0);
        check_after("b2b second", 4'hF, 1'b1);
    endtask

    task automatic test_mid_reset;
        int seen;
        a     = 4'h7;
        b     = 4'h3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'h0 || borrow_out !== 1'b0) begin
            fails++;
            $display("FAIL mid reset: busy=%b done=%b diff=%h bor=%b, want 0 0 0 0",
                     busy, done, diff, borrow_out);
        end
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 2 * W + 2; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL mid reset ghost: %0d busy/done cycles seen, want 0", seen);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_zero();
        test_back_to_back();
        test_mid_reset();
        test_basic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
